// File: rtl/usr_pkg.sv
// Shared definitions for the universal shift register and its command sequencer:
// sel/op encodings, sequencer state type and op classification helper.
package usr_pkg;

    localparam logic [2:0] SISO = 3'b000;
    localparam logic [2:0] SIPO = 3'b001;
    localparam logic [2:0] PISO = 3'b010;
    localparam logic [2:0] PIPO = 3'b011;
    localparam logic [2:0] LSO  = 3'b100;
    localparam logic [2:0] RSO  = 3'b101;
    localparam logic [2:0] ROL  = 3'b110;
    localparam logic [2:0] ROR  = 3'b111;

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_LOAD  = 2'b01,
        S_SHIFT = 2'b10,
        S_DONE  = 2'b11
    } state_t;

    // Serial-in ops fill the register from sin and never take a parallel load.
    function automatic logic op_needs_load(input logic [2:0] op);
        return !((op == SISO) || (op == SIPO));
    endfunction

endpackage

// File: rtl/usr.sv
// Universal shift register, n bits wide, no enable: it updates on every edge.
// Serial modes take their input bit from pin[n-1] and shift right.
module usr
    import usr_pkg::*;
#(
    parameter int n = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [2:0]   sel,
    input  logic         ld,
    input  logic [n-1:0] pin,
    output logic [n-1:0] pout
);

    logic [n-1:0] q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q <= '0;
        end else begin
            case (sel)
                SISO, SIPO: q <= {pin[n-1], q[n-1:1]};
                PISO:       q <= ld ? pin : {1'b0, q[n-1:1]};
                PIPO:       q <= pin;
                LSO:        q <= ld ? pin : {q[n-2:0], 1'b0};
                RSO:        q <= ld ? pin : {1'b0, q[n-1:1]};
                ROL:        q <= ld ? pin : {q[n-2:0], q[n-1]};
                ROR:        q <= ld ? pin : {q[0], q[n-1:1]};
                default:    q <= q;
            endcase
        end
    end

    assign pout = q;

endmodule

// File: rtl/usr_bitcnt.sv
// Loadable down-counter for the sequencer's shift count; stops at zero.
module usr_bitcnt #(
    parameter int CW = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic          dec,
    input  logic [CW-1:0] din,
    output logic          last,
    output logic          zero
);

    logic [CW-1:0] count;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (load) begin
            count <= din;
        end else if (dec && (count != '0)) begin
            count <= count - CW'(1);
        end
    end

    assign last = (count == CW'(1));
    assign zero = (count == '0);

endmodule

// File: rtl/usr_seq.sv
// Command sequencer driving a usr instance: load, shift k times, report result.
// Optional abort input/aborted output enabled by defining USR_SEQ_ABORT_EN.
module usr_seq
    import usr_pkg::*;
#(
    parameter int N  = 4,
    parameter int CW = $clog2(N) + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [2:0]    cmd_op,
    input  logic [N-1:0]  cmd_data,
    input  logic [CW-1:0] cmd_cnt,
    input  logic          sin,
    output logic [2:0]    sr_sel,
    output logic          sr_ld,
    output logic [N-1:0]  sr_pin,
    input  logic [N-1:0]  sr_pout,
    output logic [N-1:0]  result,
    output logic          done
`ifdef USR_SEQ_ABORT_EN
    ,
    input  logic          abort,
    output logic          aborted
`endif
);

    state_t       state;
    state_t       next_state;
    logic [2:0]   op_q;
    logic [N-1:0] data_q;
    logic         accept;
    logic         cnt_load;
    logic         cnt_dec;
    logic         cnt_last;
    logic         cnt_zero;
`ifdef USR_SEQ_ABORT_EN
    logic         abort_set;
    logic         abort_q;
`endif

    usr_bitcnt #(
        .CW (CW)
    ) u_bitcnt (
        .clk  (clk),
        .rst  (rst),
        .load (cnt_load),
        .dec  (cnt_dec),
        .din  (cmd_cnt),
        .last (cnt_last),
        .zero (cnt_zero)
    );

    // Default drive is the hold rule: reload the register with its own value.
    always_comb begin
        next_state = state;
        cmd_ready  = 1'b0;
        sr_sel     = PIPO;
        sr_ld      = 1'b0;
        sr_pin     = sr_pout;
        accept     = 1'b0;
        cnt_load   = 1'b0;
        cnt_dec    = 1'b0;
`ifdef USR_SEQ_ABORT_EN
        abort_set  = 1'b0;
`endif
        case (state)
            S_IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    accept   = 1'b1;
                    cnt_load = 1'b1;
                    if (op_needs_load(cmd_op)) begin
                        next_state = S_LOAD;
                    end else if (cmd_cnt == '0) begin
                        next_state = S_DONE;
                    end else begin
                        next_state = S_SHIFT;
                    end
                end
            end
            S_LOAD: begin
                sr_sel = op_q;
                sr_pin = data_q;
                sr_ld  = (op_q != PIPO);
                if ((op_q == PIPO) || cnt_zero) begin
                    next_state = S_DONE;
                end else begin
                    next_state = S_SHIFT;
                end
            end
            S_SHIFT: begin
                sr_sel  = op_q;
                sr_pin  = {sin, {(N-1){1'b0}}};
                cnt_dec = 1'b1;
                if (cnt_last) begin
                    next_state = S_DONE;
                end
            end
            S_DONE: begin
                next_state = S_IDLE;
            end
            default: begin
                next_state = S_IDLE;
            end
        endcase
`ifdef USR_SEQ_ABORT_EN
        if (abort && ((state == S_LOAD) || (state == S_SHIFT))) begin
            next_state = S_DONE;
            abort_set  = 1'b1;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= S_IDLE;
            op_q   <= '0;
            data_q <= '0;
            result <= '0;
            done   <= 1'b0;
        end else begin
            state <= next_state;
            done  <= 1'b0;
            if (accept) begin
                op_q   <= cmd_op;
                data_q <= cmd_data;
            end
            if (state == S_DONE) begin
                result <= sr_pout;
                done   <= 1'b1;
            end
        end
    end

`ifdef USR_SEQ_ABORT_EN
    // The abort flag survives until the DONE cycle so aborted lines up with done.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            abort_q <= 1'b0;
            aborted <= 1'b0;
        end else begin
            aborted <= 1'b0;
            if (abort_set) begin
                abort_q <= 1'b1;
            end else if (state == S_DONE) begin
                abort_q <= 1'b0;
                aborted <= abort_q;
            end
        end
    end
`endif

endmodule

// File: tb/tb_usr_seq.sv
// Directed bench for usr_seq paired with a usr instance (N=4).
module tb_usr_seq;
    import usr_pkg::*;

    localparam int N  = 4;
    localparam int CW = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic [2:0]    cmd_op = 3'b000;
    logic [N-1:0]  cmd_data = '0;
    logic [CW-1:0] cmd_cnt = '0;
    logic          sin = 1'b0;
    logic [2:0]    sr_sel;
    logic          sr_ld;
    logic [N-1:0]  sr_pin;
    logic [N-1:0]  sr_pout;
    logic [N-1:0]  result;
    logic          done;
`ifdef USR_SEQ_ABORT_EN
    logic          abort = 1'b0;
    logic          aborted;
`endif

    int total = 0;
    int bad   = 0;
    int lat;
    int busy;

    always #5 clk = ~clk;

    usr_seq #(.N(N), .CW(CW)) u_seq (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_data  (cmd_data),
        .cmd_cnt   (cmd_cnt),
        .sin       (sin),
        .sr_sel    (sr_sel),
        .sr_ld     (sr_ld),
        .sr_pin    (sr_pin),
        .sr_pout   (sr_pout),
        .result    (result),
        .done      (done)
`ifdef USR_SEQ_ABORT_EN
        ,
        .abort     (abort),
        .aborted   (aborted)
`endif
    );

    usr #(.n(N)) u_usr (
        .clk  (clk),
        .rst  (rst),
        .sel  (sr_sel),
        .ld   (sr_ld),
        .pin  (sr_pin),
        .pout (sr_pout)
    );

    // Present a command and return #1 after the accepting edge, with cmd_* scrambled.
    task automatic send(input logic [2:0] op, input logic [N-1:0] d, input logic [CW-1:0] c);
        cmd_op    = op;
        cmd_data  = d;
        cmd_cnt   = c;
        cmd_valid = 1'b1;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        cmd_op    = ROR;
        cmd_data  = 4'b0101;
        cmd_cnt   = 3'd7;
    endtask

    task automatic wait_done(output int l, output int b);
        l = -1;
        b = 0;
        if (!cmd_ready) b++;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk);
            #1;
            if (done) begin
                l = i;
                break;
            end
            if (!cmd_ready) b++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        total++; if (cmd_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b exp=1", cmd_ready); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", done); end
        total++; if (result !== 4'b0000) begin bad++; $display("FAIL reset_result got=%b exp=0000", result); end
        total++; if (sr_sel !== 3'b011) begin bad++; $display("FAIL reset_sel got=%b exp=011", sr_sel); end
        total++; if (sr_ld !== 1'b0) begin bad++; $display("FAIL reset_ld got=%b exp=0", sr_ld); end
        total++; if (sr_pin !== sr_pout) begin bad++; $display("FAIL reset_hold got=%b exp=%b", sr_pin, sr_pout); end
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_rol();
        send(ROL, 4'b1001, 3'd1);
        wait_done(lat, busy);
        total++; if (lat !== 3) begin bad++; $display("FAIL rol_latency got=%0d exp=3", lat); end
        total++; if (busy !== 3) begin bad++; $display("FAIL rol_busy got=%0d exp=3", busy); end
        total++; if (result !== 4'b0011) begin bad++; $display("FAIL rol_result got=%b exp=0011", result); end
        @(posedge clk);
        #1;
        total++; if (done !== 1'b0) begin bad++; $display("FAIL rol_done_clear got=%b exp=0", done); end
    endtask

    task automatic test_shift_wrap();
        send(LSO, 4'b0011, 3'd2);
        wait_done(lat, busy);
        total++; if (lat !== 4) begin bad++; $display("FAIL lso_latency got=%0d exp=4", lat); end
        total++; if (result !== 4'b1100) begin bad++; $display("FAIL lso_result got=%b exp=1100", result); end
        send(ROR, 4'b0001, 3'd5);
        wait_done(lat, busy);
        total++; if (lat !== 7) begin bad++; $display("FAIL ror_latency got=%0d exp=7", lat); end
        total++; if (result !== 4'b1000) begin bad++; $display("FAIL ror_result got=%b exp=1000", result); end
        send(RSO, 4'b1111, 3'd7);
        wait_done(lat, busy);
        total++; if (result !== 4'b0000) begin bad++; $display("FAIL rso_sat_result got=%b exp=0000", result); end
    endtask

    task automatic test_siso();
        send(SISO, 4'b1111, 3'd4);
        sin = 1'b1;
        @(posedge clk); #1; sin = 1'b0;
        @(posedge clk); #1; sin = 1'b1;
        @(posedge clk); #1; sin = 1'b1;
        @(posedge clk); #1; sin = 1'b0;
        total++; if (done !== 1'b0) begin bad++; $display("FAIL siso_early_done got=%b exp=0", done); end
        @(posedge clk); #1;
        total++; if (done !== 1'b1) begin bad++; $display("FAIL siso_done_at5 got=%b exp=1", done); end
        total++; if (result !== 4'b1101) begin bad++; $display("FAIL siso_result got=%b exp=1101", result); end
    endtask

    task automatic test_back_to_back();
        send(ROL, 4'b0110, 3'd0);
        wait_done(lat, busy);
        total++; if (lat !== 2) begin bad++; $display("FAIL cnt0_latency got=%0d exp=2", lat); end
        total++; if (result !== 4'b0110) begin bad++; $display("FAIL cnt0_result got=%b exp=0110", result); end
        total++; if (cmd_ready !== 1'b1) begin bad++; $display("FAIL b2b_ready got=%b exp=1", cmd_ready); end
        send(PIPO, 4'b1010, 3'd3);
        total++; if (cmd_ready !== 1'b0) begin bad++; $display("FAIL b2b_accept got=%b exp=0", cmd_ready); end
        wait_done(lat, busy);
        total++; if (lat !== 2) begin bad++; $display("FAIL pipo_latency got=%0d exp=2", lat); end
        total++; if (result !== 4'b1010) begin bad++; $display("FAIL pipo_result got=%b exp=1010", result); end
        busy = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (sr_pout !== 4'b1010 || sr_sel !== PIPO) busy++;
        end
        total++; if (busy !== 0) begin bad++; $display("FAIL idle_hold got=%0d exp=0 bad cycles, pout=%b", busy, sr_pout); end
        send(SIPO, 4'b0000, 3'd0);
        wait_done(lat, busy);
        total++; if (lat !== 1) begin bad++; $display("FAIL sipo0_latency got=%0d exp=1", lat); end
        total++; if (result !== 4'b1010) begin bad++; $display("FAIL sipo0_result got=%b exp=1010", result); end
    endtask

    task automatic test_reset_mid();
        logic seen;
        send(RSO, 4'b1111, 3'd3);
        @(posedge clk); #1;
        @(posedge clk); #1;
        #2 rst = 1'b0;
        #1;
        total++; if (cmd_ready !== 1'b1) begin bad++; $display("FAIL midrst_ready got=%b exp=1", cmd_ready); end
        total++; if (result !== 4'b0000) begin bad++; $display("FAIL midrst_result got=%b exp=0000", result); end
        total++; if (sr_sel !== PIPO) begin bad++; $display("FAIL midrst_sel got=%b exp=011", sr_sel); end
        total++; if (sr_ld !== 1'b0) begin bad++; $display("FAIL midrst_ld got=%b exp=0", sr_ld); end
        @(negedge clk);
        rst = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            if (done) seen = 1'b1;
        end
        total++; if (seen !== 1'b0) begin bad++; $display("FAIL midrst_no_done got=%b exp=0", seen); end
        send(ROL, 4'b0001, 3'd2);
        wait_done(lat, busy);
        total++; if (lat !== 4) begin bad++; $display("FAIL after_rst_latency got=%0d exp=4", lat); end
        total++; if (result !== 4'b0100) begin bad++; $display("FAIL after_rst_result got=%b exp=0100", result); end
    endtask

`ifdef USR_SEQ_ABORT_EN
    task automatic test_abort();
        send(RSO, 4'b1000, 3'd4);
        @(posedge clk); #1;
        @(posedge clk); #1;
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        total++; if (done !== 1'b0) begin bad++; $display("FAIL abort_early_done got=%b exp=0", done); end
        @(posedge clk); #1;
        total++; if (done !== 1'b1) begin bad++; $display("FAIL abort_done got=%b exp=1", done); end
        total++; if (aborted !== 1'b1) begin bad++; $display("FAIL abort_flag got=%b exp=1", aborted); end
        total++; if (result !== 4'b0010) begin bad++; $display("FAIL abort_result got=%b exp=0010", result); end
        @(posedge clk); #1;
        total++; if (aborted !== 1'b0) begin bad++; $display("FAIL abort_clear got=%b exp=0", aborted); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL abort_done_clear got=%b exp=0", done); end
    endtask
`endif

    initial begin
        test_reset();
        test_rol();
        test_shift_wrap();
        test_siso();
        test_back_to_back();
        test_reset_mid();
`ifdef USR_SEQ_ABORT_EN
        test_abort();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
